// File: rtl/reg_file.sv
// reg_file: NUM_REGS x DATA_W register file, two combinational read ports, one write port, hardwired zero register, write-first bypass
module reg_file #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2
);
  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_we;
  logic                w_byp1, w_byp2;
  logic                w_ok1, w_ok2;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    assign w_we[i] = wr_en && (wr_addr == ADDR_W'(i)) && (i != ZERO_REG);
    // each word clears on reset and loads wr_data only when its decoder line is high
    always_ff @(posedge clk)
      if (reset) r_mem[i] <= '0;
      else if (w_we[i]) r_mem[i] <= wr_data;
  end
  assign w_byp1 = !reset && wr_en && (wr_addr == rd_addr1);
  assign w_byp2 = !reset && wr_en && (wr_addr == rd_addr2);
  assign w_ok1  = {1'b0, rd_addr1} < (ADDR_W+1)'(NUM_REGS);
  assign w_ok2  = {1'b0, rd_addr2} < (ADDR_W+1)'(NUM_REGS);
  // read priority: zero register, then same-cycle write bypass, then stored word
  always_comb begin
    rd_data1 = (rd_addr1 == ADDR_W'(ZERO_REG)) ? '0 : w_byp1 ? wr_data : w_ok1 ? r_mem[rd_addr1] : '0;
    rd_data2 = (rd_addr2 == ADDR_W'(ZERO_REG)) ? '0 : w_byp2 ? wr_data : w_ok2 ? r_mem[rd_addr2] : '0;
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed checks plus per-cycle comparison against an array model of the register file
module tb_reg_file;
  logic        clk = 0;
  logic        reset = 1;
  logic        wr_en = 0;
  logic [4:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
  logic [63:0] rd_data1, rd_data2;
  int checks = 0, failures = 0;
  bit started = 0;
  logic [63:0] m [32];

  reg_file dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_addr2(rd_addr2), .rd_data2(rd_data2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] expect_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (!reset && wr_en && wr_addr == a) return wr_data;
    return m[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) for (int i = 0; i < 32; i++) m[i] = '0;
    else if (wr_en && wr_addr != 5'd31) m[wr_addr] = wr_data;
  end

  always @(negedge clk) if (started) begin
    chk("model_p1", rd_data1, expect_rd(rd_addr1));
    chk("model_p2", rd_data2, expect_rd(rd_addr2));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1;
    rd_addr2 = a2;
    #2;
  endtask

  initial begin
    tick;
    reset = 0;
    started = 1;
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("reset_p1", rd_data1, 64'd0);
      chk("reset_p2", rd_data2, 64'd0);
      #8;
    end
    wr_en = 1; wr_addr = 5; wr_data = 64'hDEAD_BEEF_0000_0001;
    tick;
    wr_en = 0;
    rd(5, 6);
    chk("x5_read", rd_data1, 64'hDEAD_BEEF_0000_0001);
    chk("x6_zero", rd_data2, 64'd0);
    tick;
    wr_en = 1; wr_addr = 31; wr_data = '1;
    rd(31, 31);
    chk("xzr_byp_p1", rd_data1, 64'd0);
    chk("xzr_byp_p2", rd_data2, 64'd0);
    tick;
    wr_en = 0;
    rd(31, 31);
    chk("xzr_after_p1", rd_data1, 64'd0);
    chk("xzr_after_p2", rd_data2, 64'd0);
    tick;
    wr_en = 1; wr_addr = 9; wr_data = 64'h1234;
    rd(9, 9);
    chk("byp9_p1", rd_data1, 64'h1234);
    chk("byp9_p2", rd_data2, 64'h1234);
    tick;
    wr_en = 0;
    rd(9, 9);
    chk("x9_p1", rd_data1, 64'h1234);
    chk("x9_p2", rd_data2, 64'h1234);
    tick;
    wr_en = 1; wr_addr = 3; wr_data = 64'hAA;
    tick;
    reset = 1; wr_en = 1; wr_addr = 3; wr_data = 64'hBB;
    rd(3, 5);
    chk("rst_hold_x3", rd_data1, 64'hAA);
    chk("rst_hold_x5", rd_data2, 64'hDEAD_BEEF_0000_0001);
    tick;
    reset = 0; wr_en = 0;
    rd(3, 5);
    chk("rst_x3", rd_data1, 64'd0);
    chk("rst_x5", rd_data2, 64'd0);
    tick;
    for (int i = 0; i < 31; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 64'(i * 32'h0101);
      tick;
    end
    wr_en = 0;
    for (int k = 0; k < 31; k++) begin
      rd(5'(k), 5'(30 - k));
      chk("fill_p1", rd_data1, 64'(k * 32'h0101));
      chk("fill_p2", rd_data2, 64'((30 - k) * 32'h0101));
      #8;
    end
    chk("fill_x30", m[30], 64'h1E1E);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
